ref_read_arbiter: RTL and testbench
===================================

# ref_read_arbiter

Shares one DRAM reference-reader port between `NUM_ENGINES` Smith-Waterman engines. Each engine posts a reference read request (address and block count). The arbiter grants one engine at a time in round-robin order and issues that engine's request to the reader. It then steers the returned reference blocks to the granted engine until all requested blocks have transferred. It sits between the engines' reference interfaces and the single DRAM reference reader in the multi-engine top level.

## Interface
- `NUM_ENGINES`, 4, number of requesting engines (≥2)
- `REF_LENGTH`, 128, bases per reference block; block width is 2*`REF_LENGTH`
- `clk` in 1: engine clock
- `rst` in 1: asynchronous, active-low reset
- `eng_ref_addr_in` in 25*`NUM_ENGINES`: per-engine DRAM start address, engine i at bits [25i+24:25i]
- `eng_ref_length_in` in 25*`NUM_ENGINES`: per-engine block count, same packing
- `eng_ref_info_valid_in` in `NUM_ENGINES`: per-engine request valid
- `eng_ref_info_rdy_out` out `NUM_ENGINES`: one-cycle request accept pulse
- `eng_ref_seq_block_out` out 2*`REF_LENGTH`: block data, broadcast to all engines
- `eng_ref_seq_block_valid_out` out `NUM_ENGINES`: block valid, granted engine only
- `eng_ref_seq_block_rdy_in` in `NUM_ENGINES`: per-engine block accept
- `rd_ref_addr_out` out 25: address to reader
- `rd_ref_length_out` out 25: block count to reader
- `rd_ref_info_valid_out` out 1: request valid to reader
- `rd_ref_info_rdy_in` in 1: reader accepts request
- `rd_ref_seq_block_in` in 2*`REF_LENGTH`: block data from reader
- `rd_ref_seq_block_valid_in` in 1: reader block valid
- `rd_ref_seq_block_rdy_out` out 1: block accept to reader
- `grant_out` out `NUM_ENGINES`: one-hot current owner; zero when idle
- `busy_out` out 1: state ≠ IDLE

## Operation
- FSM states: IDLE, ISSUE, STREAM.
- **IDLE**
  - If any `eng_ref_info_valid_in` bit is set, pick the first requester searching from `last+1` modulo `NUM_ENGINES`.
  - Register the winner's address, length and one-hot grant. Pulse `eng_ref_info_rdy_out[g]` for exactly one cycle, asserted on the same edge as the IDLE→ISSUE transition.
  - Set `last` = g.
  - If the latched length is 0: pulse the rdy, set no grant, stay in IDLE, and still advance `last`.
- **ISSUE**
  - `rd_ref_info_valid_out`=1 with the latched addr/length, held stable until `rd_ref_info_rdy_in`.
  - On handshake: load the 25-bit `blocks_left` = length and go to STREAM.
- **STREAM**
  - Combinational steering: `eng_ref_seq_block_valid_out[g]` = `rd_ref_seq_block_valid_in`; `rd_ref_seq_block_rdy_out` = `eng_ref_seq_block_rdy_in[g]`.
  - Each transfer (valid&rdy) decrements `blocks_left`. The transfer that brings it 1→0 moves the FSM to IDLE and clears `grant_out`.
- Outside STREAM: `rd_ref_seq_block_rdy_out`=0 and every `eng_ref_seq_block_valid_out`=0; reader blocks stall.
- `eng_ref_seq_block_out` = `rd_ref_seq_block_in` always.
- Engines hold valid, addr and length stable until their rdy pulse, then deassert valid on the next cycle. Valid seen in a later IDLE cycle is a new request.
- Requesters that are not granted may drop valid at any time; this has no effect on the arbiter.

## Timing
- Reset (`rst`=0, asynchronous):
  - FSM→IDLE, `last`=`NUM_ENGINES`-1 so engine 0 wins first.
  - `blocks_left`=0.
  - All outputs 0: rdy pulses, grant, busy, `rd_ref_info_valid_out`, and `rd_ref_addr_out`/`rd_ref_length_out` (zero data).
- Reset mid-operation aborts the transfer immediately. The reader is reset by the same `rst`.
- Request latency: request sampled in IDLE at edge N gives rdy pulse and `rd_ref_info_valid_out` high in cycle N+1.
- Block path: zero-cycle pass-through in both directions.
- Turnaround: one IDLE cycle after the final block before the next arbitration.
- Simultaneous requests: exactly one is granted; the others wait.
- Back-to-back use by a single requester is allowed when it is the only requester.
- `last` wraps from `NUM_ENGINES`-1 to 0.

## Structure
- Shared package `sw_pkg`: `REF_ADDR_W`=25, `REF_LEN_W`=25, FSM state encoding `ref_arb_state_t`.
- Sub-module `rr_arbiter`: parameterized round-robin priority picker (request vector, last pointer → one-hot grant, index); purely combinational.

## Test plan
- Single request, engine 2, addr 0x100, len 3 → `rd_ref_info_valid_out` with 0x100/3 one cycle later; exactly 3 blocks delivered only to engine 2; `busy_out` falls after the 3rd transfer.
- All 4 engines requesting continuously with len 1 → grant order 0,1,2,3,0; each grant has one IDLE bubble.
- Len 0 request from engine 1 → one rdy pulse to engine 1, `rd_ref_info_valid_out` never asserts, `last`=1.
- Backpressure: granted engine drops `eng_ref_seq_block_rdy_in` for 5 cycles mid-stream, and the reader holds `rd_ref_info_rdy_in` low for 4 cycles → no block lost or duplicated; addr/len remain stable during the wait.
- `rst` asserted during STREAM with 10 of 20 blocks sent → all outputs 0 asynchronously; after release, engine 0 wins the next arbitration.

Source files
------------

// File: rtl/sw_pkg.sv
// rtl/sw_pkg.sv - shared widths and state encoding for the reference read path
//
// Purpose: common definitions used by the reference arbiter and its picker.
//   REF_ADDR_W      : DRAM reference address width
//   REF_LEN_W       : reference block-count width
//   ref_arb_state_t : arbiter FSM encoding
//   rr_wrap         : modular wrap for round-robin index arithmetic
package sw_pkg;

  localparam int REF_ADDR_W = 25;
  localparam int REF_LEN_W  = 25;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ISSUE  = 2'd1,
    ARB_STREAM = 2'd2
  } ref_arb_state_t;

  // Wrap an index that is at most one period past the modulus.
  function automatic int rr_wrap(input int v, input int n);
    return (v >= n) ? (v - n) : v;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin priority picker
//
// Purpose: choose the first asserted request searching upward from last_i+1,
// wrapping modulo N, so the previous winner has the lowest priority.
// Ports:
//   req_i   : request vector
//   last_i  : index of the previous winner
//   grant_o : one-hot winner (zero when no request)
//   idx_o   : binary index of the winner
//   valid_o : at least one request present
module rr_arbiter
  import sw_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Offsets 1..N visit every requester once, ending on last_i itself so a
  // lone requester can win back-to-back.
  always_comb begin
    grant_o  = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= N; k++) begin
      cand     = rr_wrap(int'(last_i) + k, N);
      cand_idx = IDX_W'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o           = 1'b1;
        grant_o[cand_idx] = 1'b1;
        idx_o             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/ref_read_arbiter.sv
// rtl/ref_read_arbiter.sv - round-robin sharing of one DRAM reference reader between engines
//
// Purpose: accept one engine's reference read request at a time, forward it to
// the reader, then steer the returned blocks to that engine until the
// requested count has transferred.
// Ports:
//   clk, rst                    : clock, asynchronous active-low reset
//   eng_ref_addr_in/length_in   : per-engine request, 25 bits per engine packed
//   eng_ref_info_valid_in       : per-engine request valid
//   eng_ref_info_rdy_out        : one-cycle accept pulse to the winner
//   eng_ref_seq_block_out       : block data broadcast to all engines
//   eng_ref_seq_block_valid_out : block valid, owning engine only
//   eng_ref_seq_block_rdy_in    : per-engine block accept
//   rd_ref_addr/length_out      : latched request towards the reader
//   rd_ref_info_valid_out/rdy_in: request handshake with the reader
//   rd_ref_seq_block_in/valid_in: block stream from the reader
//   rd_ref_seq_block_rdy_out    : block accept towards the reader
//   grant_out                   : one-hot current owner, zero when idle
//   busy_out                    : arbiter not idle
module ref_read_arbiter
  import sw_pkg::*;
#(
  parameter int NUM_ENGINES = 4,
  parameter int REF_LENGTH  = 128
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [REF_ADDR_W*NUM_ENGINES-1:0] eng_ref_addr_in,
  input  logic [REF_LEN_W*NUM_ENGINES-1:0]  eng_ref_length_in,
  input  logic [NUM_ENGINES-1:0]            eng_ref_info_valid_in,
  output logic [NUM_ENGINES-1:0]            eng_ref_info_rdy_out,
  output logic [2*REF_LENGTH-1:0]           eng_ref_seq_block_out,
  output logic [NUM_ENGINES-1:0]            eng_ref_seq_block_valid_out,
  input  logic [NUM_ENGINES-1:0]            eng_ref_seq_block_rdy_in,
  output logic [REF_ADDR_W-1:0]             rd_ref_addr_out,
  output logic [REF_LEN_W-1:0]              rd_ref_length_out,
  output logic                              rd_ref_info_valid_out,
  input  logic                              rd_ref_info_rdy_in,
  input  logic [2*REF_LENGTH-1:0]           rd_ref_seq_block_in,
  input  logic                              rd_ref_seq_block_valid_in,
  output logic                              rd_ref_seq_block_rdy_out,
  output logic [NUM_ENGINES-1:0]            grant_out,
  output logic                              busy_out
);

  localparam int IDX_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

  ref_arb_state_t             state_q, state_d;
  logic [IDX_W-1:0]           last_q, last_d;
  logic [REF_ADDR_W-1:0]      addr_q, addr_d;
  logic [REF_LEN_W-1:0]       len_q, len_d;
  logic [NUM_ENGINES-1:0]     grant_q, grant_d;
  logic [REF_LEN_W-1:0]       blocks_left_q, blocks_left_d;
  logic [NUM_ENGINES-1:0]     info_rdy_q, info_rdy_d;

  logic [NUM_ENGINES-1:0]     arb_req;
  logic [NUM_ENGINES-1:0]     arb_grant;
  logic [IDX_W-1:0]           arb_idx;
  logic                       arb_valid;
  logic [REF_ADDR_W-1:0]      win_addr;
  logic [REF_LEN_W-1:0]       win_len;
  logic                       in_stream;
  logic                       blk_xfer;

  // The engine being acknowledged this cycle still shows its old valid; it
  // must not be mistaken for a fresh request (matters after a zero-length
  // request, where the arbiter is back in IDLE during the pulse).
  assign arb_req = eng_ref_info_valid_in & ~info_rdy_q;

  rr_arbiter #(
    .N     (NUM_ENGINES),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req_i   (arb_req),
    .last_i  (last_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign win_addr = eng_ref_addr_in[int'(arb_idx)*REF_ADDR_W +: REF_ADDR_W];
  assign win_len  = eng_ref_length_in[int'(arb_idx)*REF_LEN_W +: REF_LEN_W];

  // Block path is pure steering: no storage, so neither direction adds latency.
  assign in_stream                   = (state_q == ARB_STREAM);
  assign eng_ref_seq_block_out       = rd_ref_seq_block_in;
  assign eng_ref_seq_block_valid_out = (in_stream && rd_ref_seq_block_valid_in) ? grant_q : '0;
  assign rd_ref_seq_block_rdy_out    = in_stream && |(grant_q & eng_ref_seq_block_rdy_in);
  assign blk_xfer                    = rd_ref_seq_block_valid_in && rd_ref_seq_block_rdy_out;

  assign eng_ref_info_rdy_out  = info_rdy_q;
  assign rd_ref_addr_out       = addr_q;
  assign rd_ref_length_out     = len_q;
  assign rd_ref_info_valid_out = (state_q == ARB_ISSUE);
  assign grant_out             = grant_q;
  assign busy_out              = (state_q != ARB_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ARB_IDLE;
      last_q        <= IDX_W'(NUM_ENGINES - 1);
      addr_q        <= '0;
      len_q         <= '0;
      grant_q       <= '0;
      blocks_left_q <= '0;
      info_rdy_q    <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      grant_q       <= grant_d;
      blocks_left_q <= blocks_left_d;
      info_rdy_q    <= info_rdy_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    addr_d        = addr_q;
    len_d         = len_q;
    grant_d       = grant_q;
    blocks_left_d = blocks_left_q;
    info_rdy_d    = '0;

    unique case (state_q)
      ARB_IDLE: begin
        if (arb_valid) begin
          info_rdy_d = arb_grant;
          last_d     = arb_idx;
          addr_d     = win_addr;
          len_d      = win_len;
          // A zero-length request is acknowledged and consumes its turn,
          // but nothing is sent to the reader.
          if (win_len != '0) begin
            grant_d = arb_grant;
            state_d = ARB_ISSUE;
          end
        end
      end

      ARB_ISSUE: begin
        if (rd_ref_info_rdy_in) begin
          blocks_left_d = len_q;
          state_d       = ARB_STREAM;
        end
      end

      ARB_STREAM: begin
        if (blk_xfer) begin
          blocks_left_d = blocks_left_q - REF_LEN_W'(1);
          if (blocks_left_q == REF_LEN_W'(1)) begin
            grant_d = '0;
            state_d = ARB_IDLE;
          end
        end
      end

      default: begin
        grant_d = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ref_read_arbiter.sv
// tb/tb_ref_read_arbiter.sv - self-checking bench for ref_read_arbiter
module tb_ref_read_arbiter;

  localparam int N  = 4;
  localparam int RL = 128;
  localparam int BW = 2*RL;
  localparam int AW = 25;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [AW*N-1:0] eng_addr;
  logic [AW*N-1:0] eng_len;
  logic [N-1:0]    eng_valid;
  logic [N-1:0]    eng_rdy_out;
  logic [BW-1:0]   eng_blk;
  logic [N-1:0]    eng_blk_valid;
  logic [N-1:0]    eng_blk_rdy;
  logic [AW-1:0]   rd_addr;
  logic [AW-1:0]   rd_len;
  logic            rd_info_valid;
  logic            rd_info_rdy;
  logic [BW-1:0]   rd_blk;
  logic            rd_blk_valid;
  logic            rd_blk_rdy;
  logic [N-1:0]    grant;
  logic            busy;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  ref_read_arbiter #(
    .NUM_ENGINES (N),
    .REF_LENGTH  (RL)
  ) dut (
    .clk                         (clk),
    .rst                         (rst),
    .eng_ref_addr_in             (eng_addr),
    .eng_ref_length_in           (eng_len),
    .eng_ref_info_valid_in       (eng_valid),
    .eng_ref_info_rdy_out        (eng_rdy_out),
    .eng_ref_seq_block_out       (eng_blk),
    .eng_ref_seq_block_valid_out (eng_blk_valid),
    .eng_ref_seq_block_rdy_in    (eng_blk_rdy),
    .rd_ref_addr_out             (rd_addr),
    .rd_ref_length_out           (rd_len),
    .rd_ref_info_valid_out       (rd_info_valid),
    .rd_ref_info_rdy_in          (rd_info_rdy),
    .rd_ref_seq_block_in         (rd_blk),
    .rd_ref_seq_block_valid_in   (rd_blk_valid),
    .rd_ref_seq_block_rdy_out    (rd_blk_rdy),
    .grant_out                   (grant),
    .busy_out                    (busy)
  );

  function automatic logic [BW-1:0] rand_block();
    logic [BW-1:0] b;
    for (int i = 0; i < BW/32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic idle_inputs();
    eng_addr     = '0;
    eng_len      = '0;
    eng_valid    = '0;
    eng_blk_rdy  = '0;
    rd_info_rdy  = 1'b0;
    rd_blk       = '0;
    rd_blk_valid = 1'b0;
  endtask

  task automatic set_req(input int e, input logic [AW-1:0] a, input logic [AW-1:0] l);
    eng_addr[e*AW +: AW] = a;
    eng_len[e*AW +: AW]  = l;
    eng_valid[e]         = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [3*N+2+2*AW+1:0] obs;
    idle_inputs();
    rst = 1'b0;
    for (int e = 0; e < N; e++) set_req(e, AW'(e + 1), AW'(2));
    rd_info_rdy  = 1'b1;
    rd_blk_valid = 1'b1;
    rd_blk       = rand_block();
    eng_blk_rdy  = '1;
    @(negedge clk);
    @(negedge clk);
    #1;
    obs = {eng_rdy_out, grant, eng_blk_valid, busy, rd_info_valid, rd_addr, rd_len, rd_blk_rdy};
    chk_cnt++;
    if (obs !== '0) $display("FAIL reset_outputs got=%h want=0", obs);
    else pass_cnt++;
    chk_cnt++;
    if (eng_blk !== rd_blk) $display("FAIL reset_block_passthru got=%h want=%h", eng_blk, rd_blk);
    else pass_cnt++;
  endtask

  task automatic test_single();
    int n_xfer;
    do_reset();
    @(negedge clk);
    set_req(2, AW'('h100), AW'(3));
    @(negedge clk);
    #1;
    chk_cnt++;
    if (eng_rdy_out !== 4'b0100) $display("FAIL single_rdy got=%b want=0100", eng_rdy_out);
    else pass_cnt++;
    chk_cnt++;
    if ({rd_info_valid, rd_addr, rd_len} !== {1'b1, AW'('h100), AW'(3)})
      $display("FAIL single_issue got=%b/%h/%h want=1/100/3", rd_info_valid, rd_addr, rd_len);
    else pass_cnt++;
    chk_cnt++;
    if ({grant, busy} !== {4'b0100, 1'b1}) $display("FAIL single_grant got=%b/%b want=0100/1", grant, busy);
    else pass_cnt++;
    eng_valid[2] = 1'b0;
    rd_info_rdy  = 1'b1;
    @(negedge clk);
    rd_info_rdy = 1'b0;
    eng_blk_rdy = '1;
    n_xfer      = 0;
    for (int c = 0; c < 10 && busy; c++) begin
      rd_blk_valid = 1'b1;
      rd_blk       = rand_block();
      #1;
      chk_cnt++;
      if ({eng_blk_valid, rd_blk_rdy, eng_blk === rd_blk} !== {4'b0100, 1'b1, 1'b1})
        $display("FAIL single_steer xfer=%0d got=%b/%b want=0100/1", n_xfer, eng_blk_valid, rd_blk_rdy);
      else pass_cnt++;
      n_xfer++;
      @(negedge clk);
    end
    #1;
    chk_cnt++;
    if (n_xfer != 3) $display("FAIL single_count got=%0d want=3", n_xfer);
    else pass_cnt++;
    chk_cnt++;
    if ({busy, grant, eng_blk_valid, rd_blk_rdy} !== '0)
      $display("FAIL single_done got=%b/%b/%b/%b want=0", busy, grant, eng_blk_valid, rd_blk_rdy);
    else pass_cnt++;
    rd_blk_valid = 1'b0;
  endtask

  task automatic test_round_robin();
    int order[$];
    int gaps[$];
    int idle_run;
    int want[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int e = 0; e < N; e++) set_req(e, AW'('h200 + e), AW'(1));
    rd_info_rdy  = 1'b1;
    rd_blk_valid = 1'b1;
    eng_blk_rdy  = '1;
    idle_run     = 0;
    for (int c = 0; c < 60 && order.size() < 5; c++) begin
      @(negedge clk);
      if (!busy) idle_run++;
      for (int e = 0; e < N; e++) begin
        if (eng_rdy_out[e]) begin
          order.push_back(e);
          gaps.push_back(idle_run);
          idle_run     = 0;
          eng_valid[e] = 1'b0;
        end else begin
          eng_valid[e] = 1'b1;
        end
      end
    end
    chk_cnt++;
    if (order.size() != 5) $display("FAIL rr_grants got=%0d want=5", order.size());
    else pass_cnt++;
    for (int i = 0; i < order.size() && i < 5; i++) begin
      chk_cnt++;
      if (order[i] != want[i]) $display("FAIL rr_order idx=%0d got=%0d want=%0d", i, order[i], want[i]);
      else pass_cnt++;
      if (i > 0) begin
        chk_cnt++;
        if (gaps[i] != 1) $display("FAIL rr_bubble idx=%0d got=%0d want=1", i, gaps[i]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_len_zero();
    logic seen;
    do_reset();
    @(negedge clk);
    set_req(1, AW'('h55), AW'(0));
    @(negedge clk);
    #1;
    chk_cnt++;
    if ({eng_rdy_out, grant, busy, rd_info_valid} !== {4'b0010, 4'b0000, 1'b0, 1'b0})
      $display("FAIL len0_ack got=%b/%b/%b/%b want=0010/0000/0/0", eng_rdy_out, grant, busy, rd_info_valid);
    else pass_cnt++;
    eng_valid[1] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      seen = seen | rd_info_valid | busy | (|eng_rdy_out);
    end
    chk_cnt++;
    if (seen !== 1'b0) $display("FAIL len0_quiet got=%b want=0", seen);
    else pass_cnt++;
    for (int e = 0; e < N; e++) set_req(e, AW'('h60 + e), AW'(2));
    @(negedge clk);
    #1;
    chk_cnt++;
    if (eng_rdy_out !== 4'b0100) $display("FAIL len0_last got=%b want=0100", eng_rdy_out);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [BW-1:0] got[$];
    int k;
    do_reset();
    @(negedge clk);
    set_req(3, AW'('h1ABCDE), AW'(6));
    @(negedge clk);
    eng_valid[3] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk_cnt++;
      if ({rd_info_valid, rd_addr, rd_len} !== {1'b1, AW'('h1ABCDE), AW'(6)})
        $display("FAIL bp_hold cyc=%0d got=%b/%h/%h want=1/1abcde/6", c, rd_info_valid, rd_addr, rd_len);
      else pass_cnt++;
      @(negedge clk);
    end
    rd_info_rdy = 1'b1;
    @(negedge clk);
    rd_info_rdy = 1'b0;
    k = 0;
    for (int c = 0; c < 40 && busy; c++) begin
      eng_blk_rdy[3] = !(c >= 2 && c < 7);
      rd_blk         = BW'(k) + BW'('hD000);
      rd_blk_valid   = 1'b1;
      #1;
      if (eng_blk_valid[3] && eng_blk_rdy[3]) got.push_back(eng_blk);
      if (!eng_blk_rdy[3]) begin
        chk_cnt++;
        if (rd_blk_rdy !== 1'b0) $display("FAIL bp_stall cyc=%0d got=%b want=0", c, rd_blk_rdy);
        else pass_cnt++;
      end
      if (rd_blk_valid && rd_blk_rdy) k++;
      @(negedge clk);
    end
    rd_blk_valid = 1'b0;
    chk_cnt++;
    if (got.size() != 6 || k != 6) $display("FAIL bp_count got=%0d/%0d want=6/6", got.size(), k);
    else pass_cnt++;
    for (int i = 0; i < got.size(); i++) begin
      chk_cnt++;
      if (got[i] !== BW'(i) + BW'('hD000)) $display("FAIL bp_data idx=%0d got=%h want=%h", i, got[i], BW'(i) + BW'('hD000));
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    logic [3*N+2+2*AW+1:0] obs;
    do_reset();
    @(negedge clk);
    set_req(2, AW'('h300), AW'(20));
    @(negedge clk);
    eng_valid[2] = 1'b0;
    rd_info_rdy  = 1'b1;
    @(negedge clk);
    rd_info_rdy  = 1'b0;
    rd_blk_valid = 1'b1;
    eng_blk_rdy  = '1;
    for (int c = 0; c < 10; c++) @(negedge clk);
    #1;
    chk_cnt++;
    if ({busy, grant, rd_blk_rdy} !== {1'b1, 4'b0100, 1'b1})
      $display("FAIL rstmid_pre got=%b/%b/%b want=1/0100/1", busy, grant, rd_blk_rdy);
    else pass_cnt++;
    #1;
    rst = 1'b0;
    #1;
    obs = {eng_rdy_out, grant, eng_blk_valid, busy, rd_info_valid, rd_addr, rd_len, rd_blk_rdy};
    chk_cnt++;
    if (obs !== '0) $display("FAIL rstmid_async got=%h want=0", obs);
    else pass_cnt++;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    for (int e = 0; e < N; e++) set_req(e, AW'('h400 + e), AW'(1));
    @(negedge clk);
    #1;
    chk_cnt++;
    if (eng_rdy_out !== 4'b0001) $display("FAIL rstmid_first got=%b want=0001", eng_rdy_out);
    else pass_cnt++;
  endtask

  // Transaction-level reference: who owns the reader, whether its request has
  // been accepted by the reader, and how many blocks it is still owed.
  task automatic test_random();
    int owner, remaining, last, ack, next_ack, cand;
    bit issued;
    logic [AW-1:0] m_addr, m_len;
    int exp_blocks[N];
    int got_blocks[N];
    logic [N-1:0] exp_rdy, exp_grant, exp_bv;
    logic exp_iv, exp_br;
    do_reset();
    owner = -1; issued = 0; remaining = 0; last = N - 1; ack = -1;
    m_addr = '0; m_len = '0;
    for (int e = 0; e < N; e++) begin exp_blocks[e] = 0; got_blocks[e] = 0; end
    for (int cyc = 0; cyc < 2200; cyc++) begin
      @(negedge clk);
      for (int e = 0; e < N; e++) begin
        if (ack == e) eng_valid[e] = 1'b0;
        else if (!eng_valid[e] && cyc < 1900 && $urandom_range(0, 3) == 0)
          set_req(e, AW'($urandom), AW'($urandom_range(0, 4)));
        eng_blk_rdy[e] = ($urandom_range(0, 3) != 0);
      end
      rd_info_rdy  = ($urandom_range(0, 2) == 0);
      rd_blk_valid = ($urandom_range(0, 2) != 0);
      rd_blk       = rand_block();
      #1;
      exp_rdy   = (ack >= 0) ? (N'(1) << ack) : '0;
      exp_grant = (owner >= 0) ? (N'(1) << owner) : '0;
      exp_iv    = (owner >= 0) && !issued;
      exp_bv    = ((owner >= 0) && issued && rd_blk_valid) ? exp_grant : '0;
      exp_br    = ((owner >= 0) && issued) ? eng_blk_rdy[owner] : 1'b0;
      chk_cnt++;
      if ({eng_rdy_out, grant, busy, rd_info_valid, eng_blk_valid, rd_blk_rdy, eng_blk === rd_blk} !==
          {exp_rdy, exp_grant, owner >= 0, exp_iv, exp_bv, exp_br, 1'b1}) begin
        $display("FAIL rand_cycle cyc=%0d got rdy=%b gnt=%b busy=%b iv=%b bv=%b br=%b want rdy=%b gnt=%b busy=%b iv=%b bv=%b br=%b",
                 cyc, eng_rdy_out, grant, busy, rd_info_valid, eng_blk_valid, rd_blk_rdy,
                 exp_rdy, exp_grant, owner >= 0, exp_iv, exp_bv, exp_br);
      end else pass_cnt++;
      if (exp_iv) begin
        chk_cnt++;
        if ({rd_addr, rd_len} !== {m_addr, m_len})
          $display("FAIL rand_req cyc=%0d got=%h/%h want=%h/%h", cyc, rd_addr, rd_len, m_addr, m_len);
        else pass_cnt++;
      end
      for (int e = 0; e < N; e++) if (eng_blk_valid[e] && eng_blk_rdy[e]) got_blocks[e]++;
      next_ack = -1;
      if (owner < 0) begin
        for (int k = 1; k <= N && next_ack < 0; k++) begin
          cand = (last + k) % N;
          if (eng_valid[cand] && cand != ack) next_ack = cand;
        end
        if (next_ack >= 0) begin
          last   = next_ack;
          m_addr = eng_addr[next_ack*AW +: AW];
          m_len  = eng_len[next_ack*AW +: AW];
          exp_blocks[next_ack] += int'(m_len);
          if (m_len != 0) begin owner = next_ack; issued = 0; end
        end
      end else if (!issued) begin
        if (rd_info_rdy) begin issued = 1; remaining = int'(m_len); end
      end else if (rd_blk_valid && eng_blk_rdy[owner]) begin
        remaining--;
        if (remaining == 0) owner = -1;
      end
      ack = next_ack;
    end
    for (int e = 0; e < N; e++) begin
      chk_cnt++;
      if (got_blocks[e] != exp_blocks[e]) $display("FAIL rand_total eng=%0d got=%0d want=%0d", e, got_blocks[e], exp_blocks[e]);
      else pass_cnt++;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_len_zero();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
